// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv
// rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv - IJTAG TDR driving select/override data of the 19-bit data mux
// Capture-shift-update register; the payload carries an even-parity bit that gates the update.
module firebird7_in_gate1_tessent_tdr_data_ctl_w19 #(
  parameter int unsigned      WIDTH       = 19,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               PARITY_EN   = 1'b1
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             parity_error
);

  localparam int unsigned SR_W = WIDTH + 2;

  logic [SR_W-1:0]  r_sr;
  logic             r_select;
  logic [WIDTH-1:0] r_data;
  logic             r_parity_error;

  logic             w_capture;
  logic             w_shift;
  logic             w_update;
  logic             w_parity_ok;

  // ce outranks se, which outranks ue; nothing acts unless the register is selected.
  assign w_capture   = ijtag_sel & ijtag_ce;
  assign w_shift     = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign w_update    = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
  assign w_parity_ok = !PARITY_EN || ((^r_sr) == 1'b0);

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr           <= '0;
      r_select       <= 1'b0;
      r_data         <= RESET_VALUE;
      r_parity_error <= 1'b0;
    end else if (w_capture) begin
      // Capturing the sticky error also clears it, so software reads it exactly once.
      r_sr           <= {r_parity_error, r_select, capture_data_in};
      r_parity_error <= 1'b0;
    end else if (w_shift) begin
      r_sr <= {ijtag_si, r_sr[SR_W-1:1]};
    end else if (w_update) begin
      if (w_parity_ok) begin
        r_select <= r_sr[WIDTH];
        r_data   <= r_sr[WIDTH-1:0];
      end else begin
        r_parity_error <= 1'b1;
      end
    end
  end

  assign ijtag_so       = r_sr[0];
  assign ijtag_select   = r_select;
  assign ijtag_data_out = r_data;
  assign parity_error   = r_parity_error;

endmodule
